// File: rtl/fetch_instruction.sv
// fetch_instruction: instruction-fetch stage.
// Owns the program counter and drives a single-outstanding instruction-memory
// read handshake. It delivers instr / next_PC_normal pairs to IF/ID and
// squashes wrong-path fetches when execute redirects the PC.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, an odd
// redirect target sets the sticky err flag and halts fetch. When it is not
// defined, the target is forced even and err stays 0.
module fetch_instruction #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        halt_in,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] next_PC_normal,
  output logic        instr_valid,
  output logic        err
);

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_SQUASH,
    S_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic        halt_pend_q, halt_pend_d;  // SQUASH exits to HALTED instead of FETCH
  logic        err_q, err_d;

  logic        accepted;     // request handed to memory this cycle
  logic        busy_after;   // a request is still outstanding after this edge
  logic        misaligned;   // odd redirect target while alignment checking is on

  // Read request: issued in FETCH, or in VALID when the held instruction drains.
  assign imem_rd   = rst_n && ((state_q == S_FETCH) || (state_q == S_VALID && !stall_in));
  assign imem_addr = pc_q;

  assign instr          = instr_q;
  assign next_PC_normal = npc_q;
  assign instr_valid    = valid_q;
  assign err            = err_q;

  // Next-state, PC and output-register update; redirect beats halt beats stall.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    npc_d       = npc_q;
    valid_d     = valid_q;
    halt_pend_d = halt_pend_q;
    err_d       = err_q;

    accepted   = imem_rd && !imem_stall;
    busy_after = accepted ? !imem_done
                          : ((state_q == S_WAIT || state_q == S_SQUASH) && !imem_done);
    misaligned = ALIGN_CHECK && redirect_pc[0];

    if (redirect_en) begin
      // Any data returned this cycle belongs to the wrong path and is dropped.
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if (misaligned) begin
        err_d       = 1'b1;
        halt_pend_d = 1'b1;
        state_d     = busy_after ? S_SQUASH : S_HALTED;
      end else begin
        pc_d        = {redirect_pc[15:1], 1'b0};
        halt_pend_d = 1'b0;
        state_d     = busy_after ? S_SQUASH : S_FETCH;
      end
    end else if (halt_in && state_q != S_HALTED) begin
      // PC stays frozen; an in-flight read must still be drained before halting.
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
      halt_pend_d = 1'b1;
      state_d     = busy_after ? S_SQUASH : S_HALTED;
    end else begin
      case (state_q)
        S_FETCH, S_VALID: begin
          // A stalled VALID simply holds everything; otherwise the held
          // instruction is consumed and this cycle acts as a FETCH.
          if (state_q == S_FETCH || !stall_in) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (accepted && imem_done) begin
              instr_d = imem_data;
              npc_d   = pc_q + 16'd2;
              pc_d    = pc_q + 16'd2;
              valid_d = 1'b1;
              state_d = S_VALID;
            end else if (accepted) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
        S_WAIT: begin
          if (imem_done) begin
            instr_d = imem_data;
            npc_d   = pc_q + 16'd2;
            pc_d    = pc_q + 16'd2;
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end
        S_SQUASH: begin
          if (imem_done) begin
            state_d     = halt_pend_q ? S_HALTED : S_FETCH;
            halt_pend_d = 1'b0;
          end
        end
        S_HALTED: begin
          state_d = S_HALTED;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      npc_q       <= 16'h0000;
      valid_q     <= 1'b0;
      halt_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      npc_q       <= npc_d;
      valid_q     <= valid_d;
      halt_pend_q <= halt_pend_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_instruction.sv
// Testbench for fetch_instruction: directed stimulus, with a scoreboard queue
// of expected instr / next_PC_normal pairs that is consumed by a monitor.
module tb_fetch_instruction;

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        halt_in;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] next_pc_normal;
  logic        instr_valid;
  logic        err;

  // Memory responder: auto_hit returns data in the acceptance cycle;
  // otherwise done and data come from man_done and man_data.
  logic        auto_hit;
  logic        man_done;
  logic [15:0] man_data;

  assign imem_done = auto_hit ? (imem_rd && !imem_stall) : man_done;
  assign imem_data = auto_hit ? (16'hA000 + {1'b0, imem_addr[15:1]} + 16'd1) : man_data;

  // Second instance for the PC wrap case; it always hits.
  logic        w_rd;
  logic [15:0] w_addr;
  logic [15:0] w_instr;
  logic [15:0] w_npc;
  logic        w_valid;
  logic        w_err;

  fetch_instruction dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_in      (stall_in),
    .halt_in       (halt_in),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .imem_rd       (imem_rd),
    .imem_addr     (imem_addr),
    .imem_stall    (imem_stall),
    .imem_done     (imem_done),
    .imem_data     (imem_data),
    .instr         (instr),
    .next_PC_normal(next_pc_normal),
    .instr_valid   (instr_valid),
    .err           (err)
  );

  fetch_instruction #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_in      (1'b0),
    .halt_in       (1'b0),
    .redirect_en   (1'b0),
    .redirect_pc   (16'h0000),
    .imem_rd       (w_rd),
    .imem_addr     (w_addr),
    .imem_stall    (1'b0),
    .imem_done     (w_rd),
    .imem_data     (16'h5A5A),
    .instr         (w_instr),
    .next_PC_normal(w_npc),
    .instr_valid   (w_valid),
    .err           (w_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] npc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_pair(input logic [15:0] i, input logic [15:0] n);
    exp_t e;
    e.instr = i;
    e.npc   = n;
    exp_q.push_back(e);
  endtask

  // Move inputs just after the rising edge, then to a mid-cycle sample point.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  // Monitor: each instruction consumed by IF/ID must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && instr_valid && !stall_in) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_instr", instr, 16'hxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr", instr, e.instr);
        check("sb_next_pc", next_pc_normal, e.npc);
      end
    end
  end

  initial begin
    rst_n       = 1'b1;
    stall_in    = 1'b0;
    halt_in     = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 16'h0000;
    imem_stall  = 1'b0;
    auto_hit    = 1'b1;
    man_done    = 1'b0;
    man_data    = 16'h0000;
    #1 rst_n = 1'b0;

    // Reset values, with imem_rd forced low despite state FETCH.
    next_cyc();
    mid();
    check("rst_imem_rd", 16'(imem_rd), 16'h0000);
    check("rst_instr_valid", 16'(instr_valid), 16'h0000);
    check("rst_instr", instr, 16'h0800);
    check("rst_next_pc", next_pc_normal, 16'h0000);
    check("rst_err", 16'(err), 16'h0000);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_wrap_addr", w_addr, 16'hFFFE);

    // C0: first request right after reset release.
    next_cyc();
    rst_n = 1'b1;
    expect_pair(16'hA001, 16'h0002);
    mid();
    check("c0_rd", 16'(imem_rd), 16'h0001);
    check("c0_addr", imem_addr, 16'h0000);
    check("wrap_c0_addr", w_addr, 16'hFFFE);

    // C1: A001 valid, fetch at 2.
    next_cyc();
    expect_pair(16'hA002, 16'h0004);
    mid();
    check("c1_valid", 16'(instr_valid), 16'h0001);
    check("c1_addr", imem_addr, 16'h0002);
    check("wrap_valid", 16'(w_valid), 16'h0001);
    check("wrap_instr", w_instr, 16'h5A5A);
    check("wrap_next_pc", w_npc, 16'h0000);
    check("wrap_second_addr", w_addr, 16'h0000);

    // C2..C4: stall while A002 is held.
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      stall_in = 1'b1;
      mid();
      check("stall_rd", 16'(imem_rd), 16'h0000);
      check("stall_instr", instr, 16'hA002);
      check("stall_next_pc", next_pc_normal, 16'h0004);
      check("stall_valid", 16'(instr_valid), 16'h0001);
    end

    // C5: stall drops, fetch at 4 issued in the same cycle.
    next_cyc();
    stall_in = 1'b0;
    expect_pair(16'hA003, 16'h0006);
    mid();
    check("unstall_rd", 16'(imem_rd), 16'h0001);
    check("unstall_addr", imem_addr, 16'h0004);

    // C6: A003 consumed; memory busy so the stream stops.
    next_cyc();
    imem_stall = 1'b1;
    mid();
    check("c6_addr", imem_addr, 16'h0006);

    // C7: redirect to 0x0010 while the request is not accepted.
    next_cyc();
    redirect_en = 1'b1;
    redirect_pc = 16'h0010;

    // C8: request to 0x0010 accepted, no data yet.
    next_cyc();
    redirect_en = 1'b0;
    imem_stall  = 1'b0;
    auto_hit    = 1'b0;
    mid();
    check("miss_addr", imem_addr, 16'h0010);
    check("miss_rd", 16'(imem_rd), 16'h0001);

    // C9: waiting.
    next_cyc();
    mid();
    check("wait_rd", 16'(imem_rd), 16'h0000);

    // C10: redirect to 0x0100 while the miss is outstanding.
    next_cyc();
    redirect_en = 1'b1;
    redirect_pc = 16'h0100;
    mid();
    check("redir_wait_rd", 16'(imem_rd), 16'h0000);

    // C11: squashing.
    next_cyc();
    redirect_en = 1'b0;
    mid();
    check("squash_rd", 16'(imem_rd), 16'h0000);
    check("squash_valid", 16'(instr_valid), 16'h0000);

    // C12: stale data for 0x0010 arrives and must be dropped.
    next_cyc();
    man_done = 1'b1;
    man_data = 16'hDEAD;
    mid();
    check("squash_done_rd", 16'(imem_rd), 16'h0000);

    // C13: fetch resumes at the redirect target.
    next_cyc();
    man_done   = 1'b0;
    imem_stall = 1'b1;
    mid();
    check("redir_addr", imem_addr, 16'h0100);
    check("redir_rd", 16'(imem_rd), 16'h0001);
    check("squashed_never_valid", 16'(instr_valid), 16'h0000);

    // C14: halt pulse with no request outstanding.
    next_cyc();
    halt_in = 1'b1;

    // C15..C24: no reads while halted.
    next_cyc();
    halt_in    = 1'b0;
    imem_stall = 1'b0;
    auto_hit   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mid();
      check("halted_rd", 16'(imem_rd), 16'h0000);
      next_cyc();
    end

    // C25: redirect out of HALTED.
    redirect_en = 1'b1;
    redirect_pc = 16'h0040;
    mid();
    check("halted_redir_rd", 16'(imem_rd), 16'h0000);

    // C26..C28: back-to-back hits from 0x0040.
    next_cyc();
    redirect_en = 1'b0;
    expect_pair(16'hA021, 16'h0042);
    mid();
    check("resume_addr0", imem_addr, 16'h0040);
    next_cyc();
    expect_pair(16'hA022, 16'h0044);
    mid();
    check("resume_addr1", imem_addr, 16'h0042);
    next_cyc();
    expect_pair(16'hA023, 16'h0046);
    mid();
    check("resume_addr2", imem_addr, 16'h0044);

    // C29: stop the stream.
    next_cyc();
    imem_stall = 1'b1;

    // C30: misaligned redirect.
    next_cyc();
    redirect_en = 1'b1;
    redirect_pc = 16'h0041;

    // C31, C32: effect of the misaligned target.
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      redirect_en = 1'b0;
      mid();
`ifdef FETCH_ALIGN_CHECK_EN
      check("misalign_err", 16'(err), 16'h0001);
      check("misalign_rd", 16'(imem_rd), 16'h0000);
`else
      check("misalign_addr", imem_addr, 16'h0040);
      check("misalign_rd", 16'(imem_rd), 16'h0001);
      check("misalign_err", 16'(err), 16'h0000);
`endif
    end

    next_cyc();
    next_cyc();
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_instruction.md
# fetch_instruction

Instruction-fetch stage that owns the program counter and drives the instruction-memory read handshake. It delivers `instr` / `next_PC_normal` pairs to the IF/ID pipeline register. It is the consuming end of the PC-redirect interface driven by the execute stage (`updatedPC` plus the branch/jump enable). In-flight fetches on the wrong path are squashed on a redirect.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `NOP_INSTR`, default 16'h0800: encoding driven on `instr` whenever `instr_valid`=0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_in`  in  1  IF/ID cannot accept this cycle (hazard unit).
- `halt_in`  in  1  HALT decoded downstream; stop fetching.
- `redirect_en`  in  1  one-cycle pulse from execute when a branch or jump is taken.
- `redirect_pc`  in  16  target PC, valid with `redirect_en`.
- `imem_rd`  out  1  read request.
- `imem_addr`  out  16  request address; equals PC whenever `imem_rd`=1.
- `imem_stall`  in  1  memory busy; request not accepted this cycle.
- `imem_done`  in  1  read data valid this cycle.
- `imem_data`  in  16  read data.
- `instr`  out  16  fetched instruction (registered).
- `next_PC_normal`  out  16  PC+2 of `instr` (registered).
- `instr_valid`  out  1  `instr` / `next_PC_normal` are valid this cycle.
- `err`  out  1  sticky misaligned-redirect flag; present only with the macro, tied 0 otherwise.

## Operation
- State machine: FETCH, WAIT, VALID, SQUASH, HALTED.
- **FETCH:** `imem_rd`=1.
  - Accepted when `imem_stall`=0.
  - Accepted with `imem_done` in the same cycle: capture the data, PC<=PC+2, go to VALID.
  - Accepted without `imem_done`: go to WAIT.
  - Not accepted: stay in FETCH.
- **WAIT:** `imem_rd`=0. On `imem_done`: capture the data, PC<=PC+2, go to VALID.
- **VALID:** `instr_valid`=1.
  - If `stall_in`=1: hold `instr`, `next_PC_normal` and PC; stay in VALID.
  - If `stall_in`=0: the instruction is consumed this cycle, and the block also behaves as FETCH in the same cycle (`imem_rd`=1 at the already-advanced PC).
- **SQUASH:** `imem_rd`=0. Wait for `imem_done`, discard the data, go to FETCH.
- **HALTED:** `imem_rd`=0, `instr_valid`=0. Leaves only on reset or `redirect_en`.
- Capture: `instr`<=`imem_data`; `next_PC_normal`<=fetched PC+2.
- Priority each cycle: `redirect_en` > `halt_in` > `stall_in`.
- **Redirect:**
  - PC<=`redirect_pc`; `instr_valid`<=0; `instr`<=NOP_INSTR.
  - If a request is outstanding after this cycle (state WAIT, or accepted this cycle without `imem_done`): go to SQUASH.
  - Otherwise: go to FETCH. Data arriving with `imem_done` in the redirect cycle is discarded.
  - Redirect while in SQUASH: update PC, remain in SQUASH.
- **Halt:**
  - PC frozen; `instr_valid`<=0.
  - With a request outstanding: go to SQUASH, then HALTED, not FETCH.
  - With no request outstanding: go directly to HALTED.
- Only one request is ever outstanding.
- Arithmetic: PC+2 is 16-bit modulo, so 16'hFFFE wraps to 16'h0000. Carry is discarded.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - PC=RESET_PC; state=FETCH.
  - `instr`=NOP_INSTR, `next_PC_normal`=16'h0000, `instr_valid`=0, `err`=0.
  - `imem_rd` forced to 0 while `rst_n`=0.
- First request is issued in the first cycle after `rst_n` rises.
- Fetch latency:
  - `imem_done` in the acceptance cycle (hit): `instr_valid`=1 in the next cycle.
  - Sustained throughput with hits and no stalls: 1 instruction per cycle.
- Redirect latency: `redirect_en` in cycle n gives `imem_addr`=`redirect_pc` in cycle n+1, or in the cycle after the squashed `imem_done`.
- `imem_rd` and `imem_addr` are combinational from state, PC and `stall_in`. All other outputs are registered.
- Reset asserted mid-WAIT: any later `imem_done` is ignored until the first FETCH after reset.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - `redirect_en` with `redirect_pc[0]`=1 sets `err`=1 (sticky until reset).
  - Goes to HALTED via SQUASH if a request is outstanding.
  - No fetch is issued to the odd address.
- `FETCH_ALIGN_CHECK_EN` not defined:
  - PC<={`redirect_pc[15:1]`,1'b0}; `err` tied 0.

## Test plan
- **Reset, hits, no stall:** memory returns 16'hA001, 16'hA002, 16'hA003 with `imem_done` in the acceptance cycle.
  - Addresses 0,2,4 on consecutive cycles.
  - `instr_valid`=1 for 3 consecutive cycles.
  - `next_PC_normal`=2,4,6.
- **Stall hold:** `stall_in`=1 for 3 cycles while in VALID with `instr`=16'hA002.
  - `instr` and `next_PC_normal` held; `imem_rd`=0.
  - Fetch at address 4 is issued in the cycle `stall_in` drops.
- **Redirect during miss:** request to 16'h0010 accepted; `imem_done` 4 cycles later; `redirect_en` with 16'h0100 in cycle 2.
  - The data returned for 16'h0010 is never made valid.
  - Next `imem_addr`=16'h0100.
- **Wrap:** RESET_PC=16'hFFFE.
  - `next_PC_normal`=16'h0000; second fetch address 16'h0000.
- **Halt then redirect:** `halt_in` pulse, then no `imem_rd` for 10 cycles, then `redirect_en`=1 with 16'h0040.
  - Fetch resumes at 16'h0040.
- **Misaligned redirect:** `redirect_en` with 16'h0041.
  - With `FETCH_ALIGN_CHECK_EN`: `err`=1 and no further `imem_rd`.
  - Without it: `imem_addr`=16'h0040 and `err`=0.
